// File: rtl/marble_pkg.sv
// Shared types for the marble release controller: game state and reservoir side.
package marble_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        WAIT    = 2'd2,
        HALT    = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

endpackage

// File: rtl/marble_reservoir.sv
// One marble reservoir: refills to CAP, decrements by one per release without
// ever wrapping below zero, and flags when it is empty.
module marble_reservoir #(
    parameter int CAP = 8,
    parameter int CW  = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reload,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          empty
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            count <= CW'(CAP);
        end else if (dec && !empty) begin
            count <= count - CW'(1);
        end
    end

    assign empty = (count == '0);

endmodule

// File: rtl/marble_release.sv
// Marble release controller: one marble in flight at a time, fed from a left and
// a right reservoir. Optional WAIT timeout enabled by MARBLE_RELEASE_TIMEOUT_EN.
module marble_release
    import marble_pkg::*;
#(
    parameter int CAP     = 8,
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          reload,
    input  logic          i_left,
    input  logic          i_right,
    output logic          o_left,
    output logic          o_right,
    output logic          busy,
    output logic          halted,
    output logic [CW-1:0] cnt_left,
    output logic [CW-1:0] cnt_right,
    output logic          timed_out
);

    state_t state, state_nx;
    side_t  side, side_nx;
    logic   left_empty, right_empty;
    logic   reload_ok;
    logic   timeout_hit;

    // A refill is only honoured while no marble is on the board.
    assign reload_ok = reload && ((state == IDLE) || (state == HALT));

    marble_reservoir #(.CAP(CAP), .CW(CW)) u_left (
        .clk    (clk),
        .rst    (rst),
        .reload (reload_ok),
        .dec    (o_left),
        .count  (cnt_left),
        .empty  (left_empty)
    );

    marble_reservoir #(.CAP(CAP), .CW(CW)) u_right (
        .clk    (clk),
        .rst    (rst),
        .reload (reload_ok),
        .dec    (o_right),
        .count  (cnt_right),
        .empty  (right_empty)
    );

`ifdef MARBLE_RELEASE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          timed_out_q;

    // Counter sits at zero outside WAIT, so each flight starts counting afresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (reload_ok) begin
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state == WAIT) && !i_left && !i_right &&
                         (wait_cnt == TW'(TIMEOUT - 1));
    assign timed_out   = timed_out_q;
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            side  <= SIDE_LEFT;
        end else begin
            state <= state_nx;
            side  <= side_nx;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nx = state;
        side_nx  = side;
        case (state)
            IDLE: begin
                if (reload) begin
                    state_nx = IDLE;
                end else if (start) begin
                    if (!left_empty) begin
                        state_nx = RELEASE;
                        side_nx  = SIDE_LEFT;
                    end else begin
                        state_nx = HALT;
                    end
                end
            end
            RELEASE: state_nx = WAIT;
            WAIT: begin
                // Left lever wins when both are hit together.
                if (i_left) begin
                    if (!left_empty) begin
                        state_nx = RELEASE;
                        side_nx  = SIDE_LEFT;
                    end else begin
                        state_nx = HALT;
                    end
                end else if (i_right) begin
                    if (!right_empty) begin
                        state_nx = RELEASE;
                        side_nx  = SIDE_RIGHT;
                    end else begin
                        state_nx = HALT;
                    end
                end else if (timeout_hit) begin
                    state_nx = HALT;
                end
            end
            HALT: begin
                if (reload) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_left  = 1'b0;
        o_right = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state)
            RELEASE: begin
                o_left  = (side == SIDE_LEFT);
                o_right = (side == SIDE_RIGHT);
            end
            WAIT:    busy   = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule
